// File: rtl/range_filter_packer.sv
// range_filter_packer
//   Range-filters a scalar element stream and packs LANES consecutive
//   elements into one wide beat with a per-lane keep mask. A beat closes
//   when all lanes are filled or when an element marked last arrives.
//
// Optional feature (compile-time macro):
//   RANGE_FILTER_PACKER_DROP_EMPTY_EN - completed groups whose keep mask is
//   all zero are discarded instead of being emitted.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input element handshake
//   in_data, in_last       element and end-of-group marker
//   cfg_lo, cfg_hi         inclusive unsigned keep range
//   out_valid/out_ready    output beat handshake
//   out_data[0:LANES-1]    beat lanes, lane 0 = oldest element
//   out_keep, out_last     per-lane keep mask, beat closed by in_last
//   kept_total             kept elements delivered in accepted beats
module range_filter_packer #(
  parameter int BIT_WIDTH = 32,
  parameter int LANES     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] cfg_lo,
  input  logic [BIT_WIDTH-1:0] cfg_hi,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_data [0:LANES-1],
  output logic [LANES-1:0]     out_keep,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [31:0]          kept_total
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANES - 1);

  generate
    if ((LANES < 2) || ((LANES % 2) != 0)) begin : g_bad_lanes
      $fatal(1, "range_filter_packer: LANES must be even and >= 2");
    end
  endgenerate

  // state | meaning
  // FILL  | accepting elements into the assembly buffer
  // DONE  | completed group held, waiting for the output slot
  typedef enum logic {FILL = 1'b0, DONE = 1'b1} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     fill_cnt_q;
  logic [BIT_WIDTH-1:0] buf_data_q [0:LANES-1];
  logic [LANES-1:0]     buf_keep_q;
  logic                 held_last_q;

  logic                 out_valid_q;
  logic [BIT_WIDTH-1:0] out_data_q [0:LANES-1];
  logic [LANES-1:0]     out_keep_q;
  logic                 out_last_q;
  logic [31:0]          kept_total_q;

  logic                 accept;
  logic                 elem_keep;
  logic                 complete;
  logic                 slot_free;
  logic                 xfer;
  logic                 drop_grp;
  logic [BIT_WIDTH-1:0] grp_data_d [0:LANES-1];
  logic [LANES-1:0]     grp_keep_d;
  logic                 grp_last_d;

  function automatic logic [31:0] popcount(input logic [LANES-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign elem_keep = (cfg_lo <= in_data) && (in_data <= cfg_hi);
  assign complete  = accept && ((fill_cnt_q == LAST_IDX) || in_last);
  assign slot_free = !out_valid_q || out_ready;
  assign xfer      = out_valid_q && out_ready;

  // The group that would be loaded this cycle: in FILL it is the buffer with
  // the incoming element merged into its lane; in DONE it is the held buffer.
  // Lanes above the fill point are already zero because the buffer is cleared
  // whenever a group leaves it.
  always_comb begin
    grp_data_d = buf_data_q;
    grp_keep_d = buf_keep_q;
    grp_last_d = held_last_q;
    if (state_q == FILL) begin
      grp_data_d[fill_cnt_q] = in_data;
      grp_keep_d[fill_cnt_q] = elem_keep;
      grp_last_d             = in_last;
    end
  end

`ifdef RANGE_FILTER_PACKER_DROP_EMPTY_EN
  assign drop_grp = (grp_keep_d == '0);
`else
  assign drop_grp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      fill_cnt_q   <= '0;
      buf_keep_q   <= '0;
      held_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      kept_total_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        buf_data_q[i] <= '0;
        out_data_q[i] <= '0;
      end
    end else begin
      if (xfer) begin
        kept_total_q <= kept_total_q + popcount(out_keep_q);
        out_valid_q  <= 1'b0;
      end

      case (state_q)
        FILL: begin
          if (complete) begin
            fill_cnt_q <= '0;
            if (drop_grp || slot_free) begin
              // Group leaves the buffer now (loaded or discarded).
              buf_keep_q <= '0;
              for (int i = 0; i < LANES; i++) begin
                buf_data_q[i] <= '0;
              end
              if (!drop_grp) begin
                out_valid_q <= 1'b1;
                out_data_q  <= grp_data_d;
                out_keep_q  <= grp_keep_d;
                out_last_q  <= grp_last_d;
              end
            end else begin
              buf_data_q  <= grp_data_d;
              buf_keep_q  <= grp_keep_d;
              held_last_q <= in_last;
              state_q     <= DONE;
            end
          end else if (accept) begin
            buf_data_q[fill_cnt_q] <= in_data;
            buf_keep_q[fill_cnt_q] <= elem_keep;
            fill_cnt_q             <= fill_cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          if (drop_grp || slot_free) begin
            buf_keep_q  <= '0;
            held_last_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
              buf_data_q[i] <= '0;
            end
            if (!drop_grp) begin
              out_valid_q <= 1'b1;
              out_data_q  <= grp_data_d;
              out_keep_q  <= grp_keep_d;
              out_last_q  <= grp_last_d;
            end
            state_q <= FILL;
          end
        end

        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_last   = out_last_q;
  assign kept_total = kept_total_q;

endmodule

// File: tb/tb_range_filter_packer.sv
// Testbench for range_filter_packer: directed scenarios plus randomized
// stimulus checked against a group-level reference model.
`timescale 1ns/1ps
module tb_range_filter_packer;
  localparam int W     = 32;
  localparam int LANES = 4;
`ifdef RANGE_FILTER_PACKER_DROP_EMPTY_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    logic [LANES-1:0][W-1:0] d;
    logic [LANES-1:0]        k;
    logic                    l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             in_ready;
  logic [W-1:0]     cfg_lo;
  logic [W-1:0]     cfg_hi;
  logic             out_valid;
  logic [W-1:0]     out_data [0:LANES-1];
  logic [LANES-1:0] out_keep;
  logic             out_last;
  logic             out_ready;
  logic [31:0]      kept_total;

  always #5 clk = ~clk;

  range_filter_packer #(.BIT_WIDTH(W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .kept_total (kept_total)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: elements accepted so far in the current group, the
  // beats the model expects, and what was actually delivered.
  beat_t                   exp_q[$];
  beat_t                   got_q[$];
  int                      xfer_cyc[$];
  logic [LANES-1:0][W-1:0] m_d;
  logic [LANES-1:0]        m_k;
  int                      m_n;
  logic [31:0]             exp_kept;
  logic                    hold_seen;
  beat_t                   hold_beat;

  function automatic beat_t mk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                               input logic [W-1:0] a2, input logic [W-1:0] a3,
                               input logic [LANES-1:0] k, input logic l);
    beat_t b;
    b.d = {a3, a2, a1, a0};
    b.k = k;
    b.l = l;
    return b;
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    for (int i = 0; i < LANES; i++) b.d[i] = out_data[i];
    b.k = out_keep;
    b.l = out_last;
    return b;
  endfunction

  task automatic clear_model();
    m_d = '0; m_k = '0; m_n = 0; exp_kept = '0;
    exp_q.delete(); got_q.delete(); xfer_cyc.delete();
    hold_seen = 1'b0;
  endtask

  // Drives one cycle of inputs (called at posedge+1), observes handshakes at
  // the following negedge, and returns at the next posedge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    beat_t b;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    @(negedge clk);
    if (in_valid && in_ready) begin
      m_d[m_n] = d;
      m_k[m_n] = (cfg_lo <= d) && (d <= cfg_hi);
      m_n++;
      if (m_n == LANES || l) begin
        b.d = m_d; b.k = m_k; b.l = l;
        if (!(DROP && (m_k == '0))) begin
          exp_q.push_back(b);
          exp_kept += 32'($countones(m_k));
        end
        m_d = '0; m_k = '0; m_n = 0;
      end
    end
    b = cur_beat();
    if (out_valid && out_ready) begin
      got_q.push_back(b);
      xfer_cyc.push_back(cyc);
    end
    hold_seen = out_valid && !out_ready;
    hold_beat = b;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    logic [W-1:0] acc;
    acc = out_data[0] | out_data[1] | out_data[2] | out_data[3];
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_keep !== '0) $display("FAIL reset_out_keep: got %b exp 0", out_keep); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b exp 0", out_last); else n_pass++;
    n_checks++; if (kept_total !== 32'd0) $display("FAIL reset_kept_total: got %0d exp 0", kept_total); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (acc !== '0) $display("FAIL reset_out_data: got %h exp 0", acc); else n_pass++;
  endtask

  task automatic test_basic();
    beat_t e;
    do_reset(1);
    cfg_lo = 32'd3; cfg_hi = 32'd6;
    for (int v = 1; v <= 8; v++) step(1'b1, W'(v), 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (got_q.size() !== 2) $display("FAIL basic_count: got %0d exp 2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2) begin
      e = mk(1, 2, 3, 4, 4'b1100, 1'b0);
      n_checks++; if (got_q[0] !== e) $display("FAIL basic_beat0: got %h exp %h", got_q[0], e); else n_pass++;
      e = mk(5, 6, 7, 8, 4'b0011, 1'b0);
      n_checks++; if (got_q[1] !== e) $display("FAIL basic_beat1: got %h exp %h", got_q[1], e); else n_pass++;
    end
    n_checks++; if (kept_total !== 32'd4) $display("FAIL basic_kept: got %0d exp 4", kept_total); else n_pass++;
  endtask

  task automatic test_last();
    beat_t e;
    do_reset(1);
    cfg_lo = 32'd0; cfg_hi = 32'd25;
    step(1'b1, 32'd10, 1'b0, 1'b1);
    step(1'b1, 32'd20, 1'b0, 1'b1);
    step(1'b1, 32'd30, 1'b1, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (got_q.size() !== 1) $display("FAIL last_count: got %0d exp 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      e = mk(10, 20, 30, 0, 4'b0011, 1'b1);
      n_checks++; if (got_q[0] !== e) $display("FAIL last_beat: got %h exp %h", got_q[0], e); else n_pass++;
    end
    n_checks++; if (kept_total !== 32'd2) $display("FAIL last_kept: got %0d exp 2", kept_total); else n_pass++;
  endtask

  task automatic test_backpressure();
    beat_t e;
    do_reset(1);
    cfg_lo = '0; cfg_hi = '1;
    for (int i = 0; i < 8; i++) step(1'b1, W'(100 + i), 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b exp 1", out_valid); else n_pass++;
    repeat (2) step(1'b1, 32'd999, 1'b0, 1'b0);
    e = mk(100, 101, 102, 103, 4'hF, 1'b0);
    n_checks++; if (cur_beat() !== e) $display("FAIL bp_hold_stable: got %h exp %h", cur_beat(), e); else n_pass++;
    n_checks++; if (got_q.size() !== 0) $display("FAIL bp_no_xfer: got %0d exp 0", got_q.size()); else n_pass++;
    repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (got_q.size() !== 2) $display("FAIL bp_count: got %0d exp 2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0] !== e) $display("FAIL bp_beat0: got %h exp %h", got_q[0], e); else n_pass++;
      e = mk(104, 105, 106, 107, 4'hF, 1'b0);
      n_checks++; if (got_q[1] !== e) $display("FAIL bp_beat1: got %h exp %h", got_q[1], e); else n_pass++;
      n_checks++; if (xfer_cyc[1] - xfer_cyc[0] !== 1) $display("FAIL bp_back_to_back: got gap %0d exp 1", xfer_cyc[1] - xfer_cyc[0]); else n_pass++;
    end
    n_checks++; if (kept_total !== 32'd8) $display("FAIL bp_kept: got %0d exp 8", kept_total); else n_pass++;
  endtask

  task automatic test_empty();
    logic [W-1:0] v [4];
    beat_t e;
    int exp_n;
    do_reset(1);
    cfg_lo = 32'd100; cfg_hi = 32'd50;
    for (int i = 0; i < 4; i++) begin
      v[i] = W'($urandom_range(0, 300));
      step(1'b1, v[i], 1'b0, 1'b1);
    end
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    exp_n = DROP ? 0 : 1;
    n_checks++; if (got_q.size() !== exp_n) $display("FAIL empty_count: got %0d exp %0d", got_q.size(), exp_n); else n_pass++;
    if (got_q.size() >= 1) begin
      e = mk(v[0], v[1], v[2], v[3], 4'b0000, 1'b0);
      n_checks++; if (got_q[0] !== e) $display("FAIL empty_beat: got %h exp %h", got_q[0], e); else n_pass++;
    end
    n_checks++; if (kept_total !== 32'd0) $display("FAIL empty_kept: got %0d exp 0", kept_total); else n_pass++;
  endtask

  task automatic test_reset_mid();
    beat_t e;
    do_reset(1);
    cfg_lo = '0; cfg_hi = '1;
    for (int i = 0; i < 6; i++) step(1'b1, W'(50 + i), 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pending: got %b exp 1", out_valid); else n_pass++;
    do_reset(1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (kept_total !== 32'd0) $display("FAIL midrst_kept: got %0d exp 0", kept_total); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b exp 1", in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b1, W'(200 + i), 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (got_q.size() !== 1) $display("FAIL midrst_count: got %0d exp 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      e = mk(200, 201, 202, 203, 4'hF, 1'b0);
      n_checks++; if (got_q[0] !== e) $display("FAIL midrst_beat: got %h exp %h", got_q[0], e); else n_pass++;
    end
  endtask

  task automatic test_stream();
    int stalls, bad_gap, bad_beat;
    do_reset(1);
    cfg_lo = 32'd64; cfg_hi = 32'd191;
    stalls = 0; bad_gap = 0; bad_beat = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b1);
      if (in_ready !== 1'b1) stalls++;
    end
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (stalls !== 0) $display("FAIL stream_stalls: got %0d exp 0", stalls); else n_pass++;
    n_checks++; if (got_q.size() !== 10) $display("FAIL stream_count: got %0d exp 10", got_q.size()); else n_pass++;
    for (int i = 1; i < xfer_cyc.size(); i++) if (xfer_cyc[i] - xfer_cyc[i-1] != LANES) bad_gap++;
    n_checks++; if (bad_gap !== 0) $display("FAIL stream_spacing: got %0d bad gaps exp 0", bad_gap); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad_beat++;
    n_checks++; if (bad_beat !== 0) $display("FAIL stream_beats: got %0d bad beats exp 0", bad_beat); else n_pass++;
    n_checks++; if (kept_total !== exp_kept) $display("FAIL stream_kept: got %0d exp %0d", kept_total, exp_kept); else n_pass++;
  endtask

  task automatic test_random();
    int unstable, bad_beat;
    logic v, l, r;
    do_reset(1);
    unstable = 0; bad_beat = 0;
    for (int i = 0; i < 500; i++) begin
      if ((i % 16) == 0) begin
        cfg_lo = W'($urandom_range(0, 15));
        cfg_hi = W'($urandom_range(0, 15));
      end
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 6) == 0);
      r = ($urandom_range(0, 2) != 0);
      step(v, W'($urandom_range(0, 15)), l, r);
      if (hold_seen && (out_valid !== 1'b1 || cur_beat() !== hold_beat)) unstable++;
    end
    repeat (12) step(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad_beat++;
    n_checks++; if (bad_beat !== 0) $display("FAIL random_beats: got %0d bad beats exp 0", bad_beat); else n_pass++;
    n_checks++; if (unstable !== 0) $display("FAIL random_stable: got %0d unstable cycles exp 0", unstable); else n_pass++;
    n_checks++; if (kept_total !== exp_kept) $display("FAIL random_kept: got %0d exp %0d", kept_total, exp_kept); else n_pass++;
  endtask

  initial begin
    cfg_lo = '0; cfg_hi = '0;
    do_reset(2);
    test_reset();
    test_basic();
    test_last();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_stream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
